ddc_mixer: RTL and testbench
============================

// Module: ddc_mixer
// PURPOSE
//  Complex down-conversion mixer directly downstream of the NCO/ADC trigger stage.
//  Multiplies the conditioned ADC sample by NCO cos/sin to produce baseband I/Q.
//  Each product is rounded, shifted and saturated. Saturation events are counted for status readback.
//  Output feeds the CIC/FIR decimation chain.
// PARAMETERS
//  ADBITWIDTH   16  signed ADC sample width (dataa_out of trigger stage)
//  NCOBITWIDTH  25  signed NCO cos/sin width (datab_out/datac_out of trigger stage)
//  OUTBITWIDTH  16  signed I/Q output width
//  RSHIFT       23  right shift applied to product after rounding (NCO unity = 2^23)
// PORTS
//  clk          in   1            system clock
//  rst          in   1            asynchronous active-low reset
//  data_in      in   ADBITWIDTH   signed ADC sample
//  cos_in       in   NCOBITWIDTH  signed NCO cosine
//  sin_in       in   NCOBITWIDTH  signed NCO sine
//  valid_in     in   1            sample qualifier
//  spec_inv     in   1            1 = invert spectrum (Q sign flipped)
//  sat_clr      in   1            synchronous clear of saturation status
//  i_out        out  OUTBITWIDTH  signed in-phase result
//  q_out        out  OUTBITWIDTH  signed quadrature result
//  valid_out    out  1            i_out/q_out qualifier
//  sat_flag     out  1            sticky: any I or Q saturation since last clear
//  sat_cnt      out  16           saturating count of samples with I or Q saturated
// BEHAVIOUR
//  - Reset (rst=0, async): i_out, q_out, valid_out, sat_flag, sat_cnt and all pipeline regs = 0.
//  - Pipeline, fixed latency 3 clk from valid_in to valid_out:
//    S1: register data_in, cos_in, sin_in, spec_inv when valid_in=1. Valid bit always shifts.
//    S2: full-precision products pi = d*cos, pq = d*sin; ADBITWIDTH+NCOBITWIDTH bits, signed.
//    S3: sign-extend by 1 bit. Q term = -pq when spec_inv=0, +pq when spec_inv=1.
//        I term = +pi. Then round/shift/saturate, register outputs.
//  - spec_inv travels with its sample: a change applies exactly to the sample that was
//    presented with it. No glitch on samples already in flight.
//  - Round: r = (p + 2^(RSHIFT-1)) >>> RSHIFT, arithmetic shift (round half toward +inf).
//  - Saturate r to [-2^(OUTBITWIDTH-1), 2^(OUTBITWIDTH-1)-1]; lane sat bit = clamp occurred.
//  - Negation of the most-negative product must not wrap; the 1-bit extension guarantees this.
//  - Stage registers load only on their valid bit; when valid_out=0, i_out/q_out hold last value.
//  - valid_in gaps are allowed any cycle; back-to-back valid gives one result per clk.
//  - Status (evaluated on S3 valid):
//    sat_flag sets when I or Q saturates.
//    sat_cnt increments by 1 per such sample (not per lane) and sticks at 16'hFFFF.
//    sat_clr=1 forces both to 0 that cycle; clear wins over a coincident increment (event lost).
//  - Reset mid-stream discards in-flight samples; first valid_out comes 3 clk after the next valid_in.
// STRUCTURE
//  - Shared include ddc_defs.vh: default widths (AD/NCO/OUT), RSHIFT, SAT_CNT_W=16.
//  - Sub-module ddc_mix_lane (instantiated for I and Q):
//    multiply, optional negate, round, saturate, sat bit.
//    Registered S2/S3, shares valid with parent.
//  - Top ddc_mixer: S1 capture, valid/spec_inv delay line, status counter.
// TESTING
//  1. data=16384, cos=2^23, sin=0, spec_inv=0, valid 1 clk -> 3 clk later valid_out=1, I=16384, Q=0.
//  2. Rounding: data=1, cos=2^22 -> I=1. data=-1, cos=2^22 -> I=0.
//     data=-1, cos=2^22+1 -> I=-1 (product below -2^22 rounds down). No sat.
//  3. Saturation: data=-32768, cos=-2^24, sin=-2^24, spec_inv=0 -> I=32767, Q=-32768.
//     Then sat_flag=1, sat_cnt=1. Same with spec_inv=1 -> Q=32767, sat_cnt=2.
//  4. spec_inv toggled on alternate valid samples, data=8192, sin=2^23, cos=0.
//     -> Q alternates -8192/+8192 in exact sample order; I=0.
//  5. Status edges: force 65536 saturating samples -> sat_cnt holds 16'hFFFF.
//     sat_clr coincident with a saturating sample -> sat_cnt=0, sat_flag=0 next clk.
//  6. Gapped valid (1,0,0,1,1) then rst low mid-stream -> outputs/valid/status 0 immediately.
//     After release, no valid_out until 3 clk after the next valid_in.

Source files
------------

// File: rtl/ddc_mixer_pkg.sv
// Shared defaults for the DDC mixer: datapath widths, product shift and status counter width.
package ddc_mixer_pkg;

    localparam int AD_W_DEF   = 16;
    localparam int NCO_W_DEF  = 25;
    localparam int OUT_W_DEF  = 16;
    localparam int RSHIFT_DEF = 23;
    localparam int SAT_CNT_W  = 16;

endpackage

// File: rtl/ddc_mixer_if.sv
// Sample/NCO input bus and baseband I/Q plus saturation status output bus of the DDC mixer.
interface ddc_mixer_if
    import ddc_mixer_pkg::*;
#(
    parameter int ADBITWIDTH  = AD_W_DEF,
    parameter int NCOBITWIDTH = NCO_W_DEF,
    parameter int OUTBITWIDTH = OUT_W_DEF
);
    logic signed [ADBITWIDTH-1:0]  data_in;
    logic signed [NCOBITWIDTH-1:0] cos_in;
    logic signed [NCOBITWIDTH-1:0] sin_in;
    logic                          valid_in;
    logic                          spec_inv;
    logic                          sat_clr;
    logic signed [OUTBITWIDTH-1:0] i_out;
    logic signed [OUTBITWIDTH-1:0] q_out;
    logic                          valid_out;
    logic                          sat_flag;
    logic [SAT_CNT_W-1:0]          sat_cnt;

    modport master (
        output data_in, cos_in, sin_in, valid_in, spec_inv, sat_clr,
        input  i_out, q_out, valid_out, sat_flag, sat_cnt
    );

    modport slave (
        input  data_in, cos_in, sin_in, valid_in, spec_inv, sat_clr,
        output i_out, q_out, valid_out, sat_flag, sat_cnt
    );
endinterface

// File: rtl/ddc_mix_lane.sv
// One mixer lane: full-precision product, optional negation, round-half-up, shift and saturate.
module ddc_mix_lane
    import ddc_mixer_pkg::*;
#(
    parameter int ADBITWIDTH  = AD_W_DEF,
    parameter int NCOBITWIDTH = NCO_W_DEF,
    parameter int OUTBITWIDTH = OUT_W_DEF,
    parameter int RSHIFT      = RSHIFT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld_p0_i,
    input  logic                          vld_p1_i,
    input  logic signed [ADBITWIDTH-1:0]  data_i,
    input  logic signed [NCOBITWIDTH-1:0] coef_i,
    input  logic                          neg_i,
    output logic signed [OUTBITWIDTH-1:0] res_o,
    output logic                          sat_d_o
);
    localparam int PW = ADBITWIDTH + NCOBITWIDTH;
    localparam int EW = PW + 1;
    localparam int RW = EW - RSHIFT;

    localparam logic signed [EW-1:0] HALF = EW'(64'd1 << (RSHIFT - 1));
    localparam logic signed [RW-1:0] MAXV = {{(RW-OUTBITWIDTH+1){1'b0}}, {(OUTBITWIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-OUTBITWIDTH+1){1'b1}}, {(OUTBITWIDTH-1){1'b0}}};

    function automatic logic signed [RW-1:0] round_shift(input logic signed [EW-1:0] t);
        logic signed [EW-1:0] s;
        s = t + HALF;
        return s[EW-1:RSHIFT];
    endfunction

    function automatic logic signed [OUTBITWIDTH-1:0] saturate(input logic signed [RW-1:0] r);
        if (r > MAXV)
            return MAXV[OUTBITWIDTH-1:0];
        else if (r < MINV)
            return MINV[OUTBITWIDTH-1:0];
        else
            return r[OUTBITWIDTH-1:0];
    endfunction

    logic signed [PW-1:0]          prod_d, prod_p1_q;
    logic                          neg_p1_q;
    logic signed [EW-1:0]          ext, term;
    logic signed [RW-1:0]          rnd;
    logic signed [OUTBITWIDTH-1:0] res_d, res_p2_q;

    assign prod_d = data_i * coef_i;

    // S2 -> S3: one guard bit lets the most-negative product negate without wrapping
    always_comb begin
        ext     = {prod_p1_q[PW-1], prod_p1_q};
        term    = neg_p1_q ? -ext : ext;
        rnd     = round_shift(term);
        res_d   = saturate(rnd);
        sat_d_o = (rnd > MAXV) || (rnd < MINV);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_p1_q <= '0;
            neg_p1_q  <= 1'b0;
            res_p2_q  <= '0;
        end else begin
            if (vld_p0_i) begin
                prod_p1_q <= prod_d;
                neg_p1_q  <= neg_i;
            end
            if (vld_p1_i)
                res_p2_q <= res_d;
        end
    end

    assign res_o = res_p2_q;
endmodule

// File: rtl/ddc_mixer.sv
// Complex down-conversion mixer: sample capture, I/Q lanes, valid delay line and saturation status.
module ddc_mixer
    import ddc_mixer_pkg::*;
#(
    parameter int ADBITWIDTH  = AD_W_DEF,
    parameter int NCOBITWIDTH = NCO_W_DEF,
    parameter int OUTBITWIDTH = OUT_W_DEF,
    parameter int RSHIFT      = RSHIFT_DEF
) (
    input logic          clk,
    input logic          rst,
    ddc_mixer_if.slave   bus
);
    logic signed [ADBITWIDTH-1:0]  data_p0_q;
    logic signed [NCOBITWIDTH-1:0] cos_p0_q, sin_p0_q;
    logic                          inv_p0_q;
    logic                          vld_p0_q, vld_p1_q, vld_p2_q;
    logic                          sat_i, sat_q;
    logic                          flag_d, flag_q;
    logic [SAT_CNT_W-1:0]          cnt_d, cnt_q;

    // S1: capture; spec_inv is latched with its own sample so in-flight samples are unaffected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_p0_q <= '0;
            cos_p0_q  <= '0;
            sin_p0_q  <= '0;
            inv_p0_q  <= 1'b0;
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
        end else begin
            if (bus.valid_in) begin
                data_p0_q <= bus.data_in;
                cos_p0_q  <= bus.cos_in;
                sin_p0_q  <= bus.sin_in;
                inv_p0_q  <= bus.spec_inv;
            end
            vld_p0_q <= bus.valid_in;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
        end
    end

    ddc_mix_lane #(
        .ADBITWIDTH (ADBITWIDTH),
        .NCOBITWIDTH(NCOBITWIDTH),
        .OUTBITWIDTH(OUTBITWIDTH),
        .RSHIFT     (RSHIFT)
    ) u_lane_i (
        .clk      (clk),
        .rst      (rst),
        .vld_p0_i (vld_p0_q),
        .vld_p1_i (vld_p1_q),
        .data_i   (data_p0_q),
        .coef_i   (cos_p0_q),
        .neg_i    (1'b0),
        .res_o    (bus.i_out),
        .sat_d_o  (sat_i)
    );

    ddc_mix_lane #(
        .ADBITWIDTH (ADBITWIDTH),
        .NCOBITWIDTH(NCOBITWIDTH),
        .OUTBITWIDTH(OUTBITWIDTH),
        .RSHIFT     (RSHIFT)
    ) u_lane_q (
        .clk      (clk),
        .rst      (rst),
        .vld_p0_i (vld_p0_q),
        .vld_p1_i (vld_p1_q),
        .data_i   (data_p0_q),
        .coef_i   (sin_p0_q),
        .neg_i    (!inv_p0_q),
        .res_o    (bus.q_out),
        .sat_d_o  (sat_q)
    );

    // S3 status: one count per sample, clear beats a coincident increment
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (bus.sat_clr) begin
            flag_d = 1'b0;
            cnt_d  = '0;
        end else if (vld_p1_q && (sat_i || sat_q)) begin
            flag_d = 1'b1;
            if (cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.valid_out = vld_p2_q;
    assign bus.sat_flag  = flag_q;
    assign bus.sat_cnt   = cnt_q;
endmodule

// File: tb/tb_ddc_mixer.sv
// Directed and randomized bench for ddc_mixer against an arithmetic reference of the mixer.
module tb_ddc_mixer;
    localparam int AD     = 16;
    localparam int NCO    = 25;
    localparam int OUT    = 16;
    localparam int RSHIFT = 23;

    typedef struct {
        int due;
        int i;
        int q;
        bit sat;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    rec_t exp_q[$];
    int   last_i   = 0;
    int   last_q   = 0;
    bit   m_flag   = 1'b0;
    int   m_cnt    = 0;

    ddc_mixer_if #(.ADBITWIDTH(AD), .NCOBITWIDTH(NCO), .OUTBITWIDTH(OUT)) bus ();

    ddc_mixer #(.ADBITWIDTH(AD), .NCOBITWIDTH(NCO), .OUTBITWIDTH(OUT), .RSHIFT(RSHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Rounded, shifted and clamped value of one signed product
    function automatic void lane_ref(input longint p, output int r, output bit sat);
        longint t;
        longint maxo;
        maxo = (longint'(1) <<< (OUT - 1)) - 1;
        t    = (p + (longint'(1) <<< (RSHIFT - 1))) >>> RSHIFT;
        sat  = 1'b0;
        if (t > maxo) begin
            t = maxo; sat = 1'b1;
        end else if (t < -maxo - 1) begin
            t = -maxo - 1; sat = 1'b1;
        end
        r = int'(t);
    endfunction

    task automatic check_all(string tag, bit exp_v);
        chk({tag, ".valid_out"}, longint'(bus.valid_out), longint'(exp_v));
        chk({tag, ".i_out"},     longint'(bus.i_out),     longint'(last_i));
        chk({tag, ".q_out"},     longint'(bus.q_out),     longint'(last_q));
        chk({tag, ".sat_flag"},  longint'(bus.sat_flag),  longint'(m_flag));
        chk({tag, ".sat_cnt"},   longint'({1'b0, bus.sat_cnt}), longint'(m_cnt));
    endtask

    task automatic step(string tag, bit v, int d, int c, int s, bit inv, bit clr);
        rec_t r;
        bit   si, sq;
        bit   exp_v;
        bus.valid_in = v;
        bus.data_in  = AD'(d);
        bus.cos_in   = NCO'(c);
        bus.sin_in   = NCO'(s);
        bus.spec_inv = inv;
        bus.sat_clr  = clr;
        @(posedge clk);
        cyc++;
        if (v) begin
            r.due = cyc + 2;
            lane_ref(longint'(d) * longint'(c), r.i, si);
            lane_ref(inv ? longint'(d) * longint'(s) : -(longint'(d) * longint'(s)), r.q, sq);
            r.sat = si | sq;
            exp_q.push_back(r);
        end
        #1;
        exp_v = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r      = exp_q.pop_front();
            exp_v  = 1'b1;
            last_i = r.i;
            last_q = r.q;
            if (r.sat) begin
                m_flag = 1'b1;
                if (m_cnt != 65535) m_cnt++;
            end
        end
        if (clr) begin
            m_flag = 1'b0;
            m_cnt  = 0;
        end
        check_all(tag, exp_v);
    endtask

    task automatic idle(string tag, int n);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_i = 0;
        last_q = 0;
        m_flag = 1'b0;
        m_cnt  = 0;
    endtask

    initial begin
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.cos_in   = '0;
        bus.sin_in   = '0;
        bus.spec_inv = 1'b0;
        bus.sat_clr  = 1'b0;
        #3;
        check_all("reset", 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Unity cosine passes the sample through on I
        step("t1", 1'b1, 16384, 1 << 23, 0, 1'b0, 1'b0);
        idle("t1", 2);
        chk("t1.i_literal", longint'(bus.i_out), 64'sd16384);
        chk("t1.q_literal", longint'(bus.q_out), 64'sd0);
        idle("t1", 2);

        // Round-half-up boundaries
        step("t2a", 1'b1, 1, 1 << 22, 0, 1'b0, 1'b0);
        step("t2b", 1'b1, -1, 1 << 22, 0, 1'b0, 1'b0);
        step("t2c", 1'b1, -1, (1 << 22) + 1, 0, 1'b0, 1'b0);
        chk("t2a.i_literal", longint'(bus.i_out), 64'sd1);
        step("t2", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("t2b.i_literal", longint'(bus.i_out), 64'sd0);
        step("t2", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("t2c.i_literal", longint'(bus.i_out), -64'sd1);
        chk("t2.no_sat", longint'(bus.sat_flag), 64'sd0);

        // Saturation both lanes, both spectrum senses
        step("t3a", 1'b1, -32768, -(1 << 24), -(1 << 24), 1'b0, 1'b0);
        step("t3b", 1'b1, -32768, -(1 << 24), -(1 << 24), 1'b1, 1'b0);
        step("t3", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("t3a.i_literal", longint'(bus.i_out), 64'sd32767);
        chk("t3a.q_literal", longint'(bus.q_out), -64'sd32768);
        chk("t3a.cnt_literal", longint'({1'b0, bus.sat_cnt}), 64'sd1);
        step("t3", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("t3b.q_literal", longint'(bus.q_out), 64'sd32767);
        chk("t3b.cnt_literal", longint'({1'b0, bus.sat_cnt}), 64'sd2);
        idle("t3", 2);

        // spec_inv alternating, back to back
        for (int k = 0; k < 6; k++) step("t4", 1'b1, 8192, 0, 1 << 23, k[0], 1'b0);
        idle("t4", 3);

        // Counter saturation at all-ones, then clear beating an increment
        step("t5clr", 1'b0, 0, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 65536; k++) step("t5", 1'b1, -32768, -(1 << 24), -(1 << 24), 1'b0, 1'b0);
        idle("t5", 3);
        chk("t5.cnt_sticky", longint'({1'b0, bus.sat_cnt}), 64'sd65535);
        step("t5x", 1'b1, -32768, -(1 << 24), 0, 1'b0, 1'b0);
        step("t5x", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        step("t5x", 1'b0, 0, 0, 0, 1'b0, 1'b1);
        chk("t5x.cnt_literal", longint'({1'b0, bus.sat_cnt}), 64'sd0);
        chk("t5x.flag_literal", longint'(bus.sat_flag), 64'sd0);
        step("t5y", 1'b1, 32767, -(1 << 24), 0, 1'b0, 1'b0);
        idle("t5y", 3);

        // Randomized traffic, mixing full-range and small operands
        for (int k = 0; k < 400; k++) begin
            int d, c, s;
            bit v, inv, clr;
            v   = ($urandom_range(0, 3) != 0);
            inv = $urandom_range(0, 1) == 1;
            clr = ($urandom_range(0, 19) == 0);
            d   = int'($urandom_range(0, 65535)) - 32768;
            c   = int'($urandom_range(0, (1 << 25) - 1)) - (1 << 24);
            s   = int'($urandom_range(0, (1 << 25) - 1)) - (1 << 24);
            if ($urandom_range(0, 1) == 1) begin
                c = c >>> 4;
                s = s >>> 4;
            end
            step("rand", v, d, c, s, inv, clr);
        end
        idle("rand", 3);

        // Gapped traffic interrupted by reset
        step("t6", 1'b1, 1000, 1 << 23, 1 << 23, 1'b0, 1'b0);
        step("t6", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        step("t6", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        step("t6", 1'b1, -32768, -(1 << 24), 0, 1'b0, 1'b0);
        step("t6", 1'b1, 2000, 1 << 23, 1 << 22, 1'b1, 1'b0);
        bus.valid_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("t6rst", 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle("t6post", 3);
        step("t6post", 1'b1, -1234, 1 << 23, 1 << 23, 1'b0, 1'b0);
        idle("t6post", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
